// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Contents:
//   state_t        - conversion/commit FSM states
//   SEG_*          - active-low {g,f,e,d,c,b,a} patterns (0 = segment lit)
//   BCD_DIGITS     - width of the BCD accumulator in digits (always 3)
//   CONV_STEPS     - shift-add-3 iterations for an 8-bit binary input
//   bcd_add3       - one "add 3 to every nibble >= 5" correction step
//   bcd_overflow   - true when a 3-digit BCD value needs more than n digits
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int BCD_DIGITS = 3;
  localparam int CONV_STEPS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;  // only g lit
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Pre-shift correction: any nibble that would reach >= 10 after doubling
  // gets 3 added so the carry lands in the next nibble.
  function automatic logic [11:0] bcd_add3(input logic [11:0] bcd);
    logic [11:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  // A valid BCD value is >= 10^n exactly when a nibble at index >= n is nonzero.
  function automatic logic bcd_overflow(input logic [11:0] bcd, input int n);
    logic ovf;
    ovf = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (i >= n && bcd[4*i +: 4] != 4'd0) ovf = 1'b1;
    end
    return ovf;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern.
// Ports:
//   digit - 4-bit BCD digit; codes 10..15 decode to a blank pattern
//   seg   - {g,f,e,d,c,b,a}, 0 = lit
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: every path assigns seg (default arm included), so no latch is inferred.
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment display controller.
// Accepts an 8-bit value over valid/ready, converts it to BCD one bit per
// cycle, and swaps the shown digits only at a frame boundary so a digit
// never mixes old and new values. A free-running scanner enables one digit
// at a time through a single shared decoder.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   val_in    - binary value to display (0..255)
//   val_valid - val_in is valid
//   val_ready - controller can accept a value (FSM idle)
//   seg       - segment drive {g,f,e,d,c,b,a}, active-low
//   an        - digit enables, active-low, one-hot-low; digit 0 = ones
//   busy      - a value is being converted or is waiting to be committed
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,      // 1..3
  parameter int REFRESH_DIV = 50000,  // cycles per scan slot, >= 2
  parameter int LZ_BLANK    = 1       // 1 = blank leading zeros
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            val_in,
  input  logic                  val_valid,
  output logic                  val_ready,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);
  localparam logic [2:0] STEP_LAST = 3'(CONV_STEPS - 1);

  // ---------------- scanner ----------------
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       scan_idx;
  logic             tick;
  logic             frame_tick;

  assign tick       = (div_cnt == DIV_LAST);
  assign frame_tick = tick && (scan_idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (tick) begin
        div_cnt  <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? 2'd0 : scan_idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // ---------------- conversion FSM ----------------
  state_t      state;
  logic [7:0]  bin_sr;
  logic [11:0] bcd_acc;
  logic [2:0]  step;
  logic [11:0] disp_bcd;
  logic        ovf;

  assign val_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd_acc  <= '0;
      step     <= '0;
      busy     <= 1'b0;
      disp_bcd <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (val_valid) begin
            bin_sr  <= val_in;
            bcd_acc <= '0;
            step    <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          // Correct, then shift the binary MSB into the BCD LSB.
          bcd_acc <= (bcd_add3(bcd_acc) << 1) | {11'd0, bin_sr[7]};
          bin_sr  <= {bin_sr[6:0], 1'b0};
          step    <= step + 3'd1;
          if (step == STEP_LAST) state <= COMMIT;
        end
        COMMIT: begin
          // Holding until the last slot of a frame ends keeps every digit of
          // one frame drawn from the same value.
          if (frame_tick) begin
            disp_bcd <= bcd_acc;
            ovf      <= bcd_overflow(bcd_acc, NUM_DIGITS);
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- digit pattern selection ----------------
  logic [3:0] cur_digit;
  logic [6:0] dec_seg;
  logic       lead_zero;
  logic [6:0] seg_next;

  assign cur_digit = disp_bcd[4*scan_idx +: 4];

  seg7_decode u_dec (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // Current digit and every displayed digit above it are zero.
  always_comb begin
    lead_zero = 1'b1;
    for (int j = 0; j < BCD_DIGITS; j++) begin
      if (j >= int'(scan_idx) && j < NUM_DIGITS && disp_bcd[4*j +: 4] != 4'd0)
        lead_zero = 1'b0;
    end
  end

  always_comb begin
    seg_next = dec_seg;
    if (ovf)
      seg_next = SEG_DASH;
    else if (LZ_BLANK != 0 && scan_idx != 2'd0 && lead_zero)
      seg_next = SEG_BLANK;
  end

  // seg and an share one register stage so they always change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= seg_next;
      an  <= ~(NUM_DIGITS'(1) << scan_idx);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl. Three instances share stimulus:
//   unit 0: NUM_DIGITS=2, LZ_BLANK=1
//   unit 1: NUM_DIGITS=2, LZ_BLANK=0
//   unit 2: NUM_DIGITS=3, LZ_BLANK=1
// All use REFRESH_DIV=4.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] val_in = 8'd0;
  logic       val_valid = 1'b0;

  logic       ready0, ready1, ready2;
  logic       busy0, busy1, busy2;
  logic [6:0] seg0, seg1, seg2;
  logic [1:0] an0, an1;
  logic [2:0] an2;

  logic [6:0] segs [3];
  logic [2:0] ans  [3];

  assign segs[0] = seg0;
  assign segs[1] = seg1;
  assign segs[2] = seg2;
  assign ans[0]  = {1'b1, an0};
  assign ans[1]  = {1'b1, an1};
  assign ans[2]  = an2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.NUM_DIGITS(2), .REFRESH_DIV(4), .LZ_BLANK(1)) u_n2 (
    .clk(clk), .rst(rst), .val_in(val_in), .val_valid(val_valid),
    .val_ready(ready0), .seg(seg0), .an(an0), .busy(busy0));

  display_scan_ctrl #(.NUM_DIGITS(2), .REFRESH_DIV(4), .LZ_BLANK(0)) u_lz0 (
    .clk(clk), .rst(rst), .val_in(val_in), .val_valid(val_valid),
    .val_ready(ready1), .seg(seg1), .an(an1), .busy(busy1));

  display_scan_ctrl #(.NUM_DIGITS(3), .REFRESH_DIV(4), .LZ_BLANK(1)) u_n3 (
    .clk(clk), .rst(rst), .val_in(val_in), .val_valid(val_valid),
    .val_ready(ready2), .seg(seg2), .an(an2), .busy(busy2));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until unit u enables digit d, then return its segments.
  task automatic sample_digit(input int u, input int d, output logic [6:0] s);
    logic [2:0] want;
    want = ~(3'b001 << d);
    s = 7'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ans[u] === want) begin
        s = segs[u];
        return;
      end
    end
  endtask

  task automatic check_digit(input string tag, input int u, input int d,
                             input logic [6:0] exp);
    logic [6:0] s;
    sample_digit(u, d, s);
    check(tag, {1'b0, s}, {1'b0, exp});
  endtask

  // Wait until every unit is idle again, plus one cycle so scanned
  // outputs reflect the committed value.
  task automatic wait_all_ready(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready0 && ready1 && ready2) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {7'd0, ok}, 8'd1);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v);
    @(negedge clk);
    val_in    = v;
    val_valid = 1'b1;
    @(negedge clk);
    val_valid = 1'b0;
  endtask

  initial begin
    int busy_cnt;

    // ---------- 1. reset ----------
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_seg", {1'b0, seg0}, 8'h7F);
    check("rst_an",  {6'd0, an0}, 8'h03);
    check("rst_an3", {5'd0, an2}, 8'h07);
    check("rst_ready", {7'd0, ready0}, 8'd1);
    check("rst_busy",  {7'd0, busy0}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_an_d0",  {6'd0, an0}, 8'h02);
      check("post_rst_seg_d0", {1'b0, seg0}, 8'h40);
    end
    check("post_rst_an3_d0", {5'd0, an2}, 8'h06);
    @(negedge clk);
    check("post_rst_an_d1",      {6'd0, an0}, 8'h01);
    check("post_rst_seg_d1",     {1'b0, seg0}, 8'h7F);
    check("post_rst_seg_d1_lz0", {1'b0, seg1}, 8'h40);
    check("post_rst_an3_d1",     {5'd0, an2}, 8'h05);

    // ---------- 2. value 81 ----------
    @(negedge clk);
    val_in = 8'd81;
    val_valid = 1'b1;
    @(negedge clk);
    val_valid = 1'b0;
    check("v81_ready_low", {7'd0, ready0}, 8'd0);
    check("v81_busy_high", {7'd0, busy0}, 8'd1);
    busy_cnt = 1;
    for (int k = 0; k < 60 && busy0; k++) begin
      @(negedge clk);
      if (busy0) busy_cnt++;
    end
    check("v81_busy_ge9", {7'd0, (busy_cnt >= 9)}, 8'd1);
    wait_all_ready("v81_done");
    check_digit("v81_d0",     0, 0, 7'h79);
    check_digit("v81_d1",     0, 1, 7'h00);
    check_digit("v81_lz0_d0", 1, 0, 7'h79);
    check_digit("v81_lz0_d1", 1, 1, 7'h00);
    check_digit("v81_n3_d2",  2, 2, 7'h7F);
    check_digit("v81_n3_d1",  2, 1, 7'h00);
    check_digit("v81_n3_d0",  2, 0, 7'h79);

    // ---------- 3. value 5 ----------
    send(8'd5);
    wait_all_ready("v5_done");
    check_digit("v5_d0",     0, 0, 7'h12);
    check_digit("v5_d1",     0, 1, 7'h7F);
    check_digit("v5_lz0_d0", 1, 0, 7'h12);
    check_digit("v5_lz0_d1", 1, 1, 7'h40);
    check_digit("v5_n3_d1",  2, 1, 7'h7F);
    check_digit("v5_n3_d2",  2, 2, 7'h7F);

    // ---------- 4. value 100 ----------
    send(8'd100);
    wait_all_ready("v100_done");
    check_digit("v100_d0",     0, 0, 7'h3F);
    check_digit("v100_d1",     0, 1, 7'h3F);
    check_digit("v100_lz0_d0", 1, 0, 7'h3F);
    check_digit("v100_n3_d0",  2, 0, 7'h40);
    check_digit("v100_n3_d1",  2, 1, 7'h40);
    check_digit("v100_n3_d2",  2, 2, 7'h79);

    // ---------- 5. value 42, then 9 held during CONV ----------
    @(negedge clk);
    val_in = 8'd42;
    val_valid = 1'b1;
    @(negedge clk);
    val_in = 8'd9;
    for (int k = 0; k < 8; k++) begin
      check("hold_ready_low", {7'd0, ready0}, 8'd0);
      @(negedge clk);
    end
    val_valid = 1'b0;
    wait_all_ready("v42_done");
    check_digit("v42_d0",    0, 0, 7'h24);
    check_digit("v42_d1",    0, 1, 7'h19);
    check_digit("v42_n3_d0", 2, 0, 7'h24);
    check_digit("v42_n3_d2", 2, 2, 7'h7F);
    check("v42_idle_busy", {7'd0, busy0}, 8'd0);

    // ---------- 6. reset during COMMIT of 81 ----------
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    val_in = 8'd81;
    val_valid = 1'b1;
    @(negedge clk);       // accepted on first edge after release
    val_valid = 1'b0;
    check("c81_busy", {7'd0, busy0}, 8'd1);
    repeat (9) @(negedge clk);  // 10 edges after release: all in COMMIT
    check("c81_pending_n2", {7'd0, busy0}, 8'd1);
    check("c81_pending_n3", {7'd0, busy2}, 8'd1);
    rst = 1'b1;
    #1;
    check("c81_rst_seg",   {1'b0, seg0}, 8'h7F);
    check("c81_rst_an",    {6'd0, an0}, 8'h03);
    check("c81_rst_ready", {7'd0, ready0}, 8'd1);
    check("c81_rst_busy",  {7'd0, busy2}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("c81_rel_ready", {7'd0, ready0}, 8'd1);
    check("c81_rel_an",    {6'd0, an0}, 8'h02);
    check("c81_rel_seg",   {1'b0, seg0}, 8'h40);
    for (int f = 0; f < 3; f++) begin
      check_digit("c81_never_d0",    0, 0, 7'h40);
      check_digit("c81_never_d1",    0, 1, 7'h7F);
      check_digit("c81_never_n3_d0", 2, 0, 7'h40);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
